// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU command encodings and NZCV bit positions.
package cpu_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_MVN = 4'b1001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100; // CMP uses the same encoding
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110; // TST uses the same encoding
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for every command that is allowed to produce an NZCV update.
  function automatic logic cmd_sets_flags(input logic [3:0] cmd);
    case (cmd)
      ALU_MOV, ALU_MVN, ALU_ADD, ALU_ADC, ALU_SUB,
      ALU_SBC, ALU_AND, ALU_ORR, ALU_EOR: cmd_sets_flags = 1'b1;
      default:                            cmd_sets_flags = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational adder/logic unit producing the NZCV result for one EX op.
module flag_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_cmd,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_shift_carry,
  input  logic             i_cin,
  input  logic             i_vin,
  output logic [3:0]       o_flags,
  output logic             o_cmd_ok
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Arithmetic ops keep the full WIDTH+1 sum so the carry-out is never lost;
  // subtraction is a + ~b + carry, so C comes out as NOT-borrow.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = i_shift_carry;
    w_v   = i_vin;
    case (i_cmd)
      ALU_ADD, ALU_ADC: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b}
              + {{WIDTH{1'b0}}, (i_cmd == ALU_ADC) ? i_cin : 1'b0};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB, ALU_SBC: begin
        w_sum = {1'b0, i_a} + {1'b0, ~i_b}
              + {{WIDTH{1'b0}}, (i_cmd == ALU_SBC) ? i_cin : 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_ORR: w_res = i_a | i_b;
      ALU_EOR: w_res = i_a ^ i_b;
      ALU_MOV: w_res = i_b;
      ALU_MVN: w_res = ~i_b;
      default: w_res = '0;
    endcase
  end

  // Assemble NZCV in architectural bit order.
  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = w_res[WIDTH-1];
    o_flags[FLAG_Z] = (w_res == '0);
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

  assign o_cmd_ok = cmd_sets_flags(i_cmd);

endmodule

// File: rtl/status_flag_unit.sv
// NZCV producer: computes flags in EX, holds them one cycle in a pending
// slot, commits them to the status register and forwards the newest value.
module status_flag_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_s_bit,
  input  logic             ex_cond_met,
  input  logic [3:0]       ex_alu_cmd,
  input  logic [WIDTH-1:0] ex_op_a,
  input  logic [WIDTH-1:0] ex_op_b,
  input  logic             ex_shift_carry,
  input  logic             stall,
  input  logic             flush,
  input  logic             sr_we,
  input  logic [3:0]       sr_wdata,
  output logic [3:0]       status_bits,
  output logic [3:0]       sr_q,
  output logic             carry_in,
  output logic             flags_pending
);

  logic [3:0] r_sr;
  logic [3:0] r_pend_flags;
  logic       r_pend_valid;
  logic [3:0] w_fwd;
  logic [3:0] w_flags;
  logic       w_cmd_ok;
  logic       w_capture;

  // Newest NZCV: an uncommitted pending value wins over the SR.
  assign w_fwd = r_pend_valid ? r_pend_flags : r_sr;

  flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .i_cmd         (ex_alu_cmd),
    .i_a           (ex_op_a),
    .i_b           (ex_op_b),
    .i_shift_carry (ex_shift_carry),
    .i_cin         (w_fwd[FLAG_C]),
    .i_vin         (w_fwd[FLAG_V]),
    .o_flags       (w_flags),
    .o_cmd_ok      (w_cmd_ok)
  );

  assign w_capture = ex_valid & ex_s_bit & ex_cond_met & w_cmd_ok
                   & ~stall & ~flush & ~sr_we;

  // Direct load beats everything; otherwise the older pending value commits
  // while a new capture (if any) refills the slot in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr         <= 4'b0000;
      r_pend_flags <= 4'b0000;
      r_pend_valid <= 1'b0;
    end else if (sr_we) begin
      r_sr         <= sr_wdata;
      r_pend_valid <= 1'b0;
    end else begin
      if (r_pend_valid) begin
        r_sr <= r_pend_flags;
      end
      if (w_capture) begin
        r_pend_flags <= w_flags;
      end
      r_pend_valid <= w_capture;
    end
  end

  assign status_bits   = w_fwd;
  assign sr_q          = r_sr;
  assign carry_in      = w_fwd[FLAG_C];
  assign flags_pending = r_pend_valid;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed table-driven bench for status_flag_unit.
module tb_status_flag_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_s_bit, ex_cond_met;
  logic [3:0]  ex_alu_cmd;
  logic [31:0] ex_op_a, ex_op_b;
  logic        ex_shift_carry, stall, flush, sr_we;
  logic [3:0]  sr_wdata;
  logic [3:0]  status_bits, sr_q;
  logic        carry_in, flags_pending;

  int checks = 0;
  int errors = 0;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_s_bit       (ex_s_bit),
    .ex_cond_met    (ex_cond_met),
    .ex_alu_cmd     (ex_alu_cmd),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_shift_carry (ex_shift_carry),
    .stall          (stall),
    .flush          (flush),
    .sr_we          (sr_we),
    .sr_wdata       (sr_wdata),
    .status_bits    (status_bits),
    .sr_q           (sr_q),
    .carry_in       (carry_in),
    .flags_pending  (flags_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, s, c;
    logic [3:0]  cmd;
    logic [31:0] a, b;
    logic        shc, stl, fl, we;
    logic [3:0]  wd;
    logic [3:0]  e_st, e_sr;
    logic        e_pend;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic s, input logic c,
                              input logic [3:0] cmd, input logic [31:0] a,
                              input logic [31:0] b, input logic shc,
                              input logic stl, input logic fl, input logic we,
                              input logic [3:0] wd, input logic [3:0] e_st,
                              input logic [3:0] e_sr, input logic e_pend);
    vec_t r;
    r.v = v; r.s = s; r.c = c; r.cmd = cmd; r.a = a; r.b = b; r.shc = shc;
    r.stl = stl; r.fl = fl; r.we = we; r.wd = wd;
    r.e_st = e_st; r.e_sr = e_sr; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] e_st,
                           input logic [3:0] e_sr, input logic e_pend);
    check({tag, ".status_bits"}, idx, status_bits, e_st);
    check({tag, ".sr_q"}, idx, sr_q, e_sr);
    check({tag, ".flags_pending"}, idx, {3'b000, flags_pending}, {3'b000, e_pend});
    check({tag, ".carry_in"}, idx, {3'b000, carry_in}, {3'b000, e_st[1]});
  endtask

  task automatic drive(input vec_t t);
    ex_valid = t.v; ex_s_bit = t.s; ex_cond_met = t.c; ex_alu_cmd = t.cmd;
    ex_op_a = t.a; ex_op_b = t.b; ex_shift_carry = t.shc;
    stall = t.stl; flush = t.fl; sr_we = t.we; sr_wdata = t.wd;
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,4'b0000,32'h0,32'h0,0,0,0,0,4'h0,4'h0,4'h0,0);
    //            v s c cmd      a             b             shc stl fl we wd       status   sr       pend
    vecs[0]  = mk(1,1,1,ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 0,  0, 0, 0, 4'b0000, 4'b1001, 4'b0000, 1);
    vecs[1]  = mk(0,0,0,ALU_ADD, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[2]  = mk(1,1,1,ALU_SUB, 32'h5,        32'h5,        0,  0, 0, 0, 4'b0000, 4'b0110, 4'b1001, 1);
    vecs[3]  = mk(1,1,1,ALU_SUB, 32'h3,        32'h5,        0,  0, 0, 0, 4'b0000, 4'b1000, 4'b0110, 1);
    vecs[4]  = mk(0,0,0,ALU_ADD, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b1000, 4'b1000, 0);
    vecs[5]  = mk(1,1,1,ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 0,  0, 0, 0, 4'b0000, 4'b0110, 4'b1000, 1);
    vecs[6]  = mk(1,1,1,ALU_ADC, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0110, 1);
    vecs[7]  = mk(0,0,0,ALU_ADD, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[8]  = mk(1,1,1,ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 0,  0, 0, 0, 4'b0000, 4'b1001, 4'b0000, 1);
    vecs[9]  = mk(1,1,0,ALU_SUB, 32'h5,        32'h5,        0,  0, 0, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[10] = mk(1,1,1,ALU_SUB, 32'h5,        32'h5,        0,  0, 1, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[11] = mk(1,1,1,ALU_SUB, 32'h5,        32'h5,        0,  1, 0, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[12] = mk(1,0,1,ALU_SUB, 32'h5,        32'h5,        0,  0, 0, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[13] = mk(1,1,1,4'b0000, 32'h5,        32'h5,        0,  0, 0, 0, 4'b0000, 4'b1001, 4'b1001, 0);
    vecs[14] = mk(1,1,1,ALU_AND, 32'h80000000, 32'h80000000, 1,  0, 0, 0, 4'b0000, 4'b1011, 4'b1001, 1);
    vecs[15] = mk(1,1,1,ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 0,  0, 0, 1, 4'b0101, 4'b0101, 4'b0101, 0);
    vecs[16] = mk(0,0,0,ALU_ADD, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b0101, 4'b0101, 0);
    vecs[17] = mk(1,1,1,ALU_MOV, 32'h12345678, 32'h00000000, 1,  0, 0, 0, 4'b0000, 4'b0111, 4'b0101, 1);
    vecs[18] = mk(1,1,1,ALU_MVN, 32'h0,        32'h00000000, 0,  0, 0, 0, 4'b0000, 4'b1001, 4'b0111, 1);
    vecs[19] = mk(1,1,1,ALU_EOR, 32'hF0F0F0F0, 32'hF0F0F0F0, 0,  0, 0, 0, 4'b0000, 4'b0101, 4'b1001, 1);
    vecs[20] = mk(1,1,1,ALU_SBC, 32'h3,        32'h5,        1,  0, 0, 0, 4'b0000, 4'b1000, 4'b0101, 1);
    vecs[21] = mk(0,0,0,ALU_ORR, 32'h0,        32'h0,        0,  0, 0, 0, 4'b0000, 4'b1000, 4'b1000, 0);

    // Reset state
    drive(idle);
    rst_n = 1'b0;
    #12;
    check_all("reset", 0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence: inputs applied while clk is low, checked #1 after the edge
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      $display("step %0d cmd=%b a=%h b=%h -> status=%b sr=%b pend=%b",
               i, vecs[i].cmd, vecs[i].a, vecs[i].b, status_bits, sr_q, flags_pending);
      check_all("vec", i, vecs[i].e_st, vecs[i].e_sr, vecs[i].e_pend);
      @(negedge clk);
    end

    // Direct load while slot is empty, then SUB overflow: 0x80000000 - 1 -> 0x7FFFFFFF, NZCV=0011
    drive(mk(0,0,0,ALU_ADD,32'h0,32'h0,0,0,0,1,4'b1110,4'h0,4'h0,0));
    @(posedge clk); #1;
    $display("seq load: status=%b sr=%b pend=%b", status_bits, sr_q, flags_pending);
    check_all("load", 0, 4'b1110, 4'b1110, 1'b0);
    @(negedge clk);
    drive(mk(1,1,1,ALU_SUB,32'h80000000,32'h1,0,0,0,0,4'h0,4'h0,4'h0,0));
    @(posedge clk); #1;
    $display("seq subv: status=%b sr=%b pend=%b", status_bits, sr_q, flags_pending);
    check_all("subv", 0, 4'b0011, 4'b1110, 1'b1);

    // Asynchronous reset in the middle of a cycle with a capture in flight
    @(negedge clk);
    drive(mk(1,1,1,ALU_ADD,32'h7FFFFFFF,32'h1,0,0,0,0,4'h0,4'h0,4'h0,0));
    @(posedge clk); #1;
    check_all("pre_rst", 0, 4'b1001, 4'b0011, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("seq async reset: status=%b sr=%b pend=%b", status_bits, sr_q, flags_pending);
    check_all("async_rst", 0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 0, 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Producer side of the NZCV condition interface.
- Computes N, Z, C, V for flag-setting ALU operations in EX and holds them one cycle in a pending slot. It then commits them to the architectural status register.
- Supplies forwarded status_bits, in NZCV order, to the condition-check logic in ID. This lets back-to-back flag-setting and conditional instructions resolve without a stall.
- Also provides a direct status-register load for context restore.

Parameters:
- WIDTH, 32, datapath width of operands.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_s_bit  in  1  instruction requests a flag update.
- ex_cond_met  in  1  instruction's condition passed.
- ex_alu_cmd  in  4  ALU command; encoding is in the shared package.
- ex_op_a  in  WIDTH  ALU operand A (Rn value).
- ex_op_b  in  WIDTH  ALU operand B (shifter output).
- ex_shift_carry  in  1  shifter carry-out, used for C on logic/move operations.
- stall  in  1  EX held; suppresses capture.
- flush  in  1  EX instruction killed; suppresses capture.
- sr_we  in  1  direct status-register load.
- sr_wdata  in  4  NZCV value for the direct load.
- status_bits  out  4  forwarded NZCV: the pending value if present, otherwise the committed SR.
- sr_q  out  4  committed architectural NZCV.
- carry_in  out  1  forwarded C, for the ALU's ADC/SBC.
- flags_pending  out  1  pending slot valid.

Behaviour:
- Reset (async, rst_n=0): sr=4'b0000, pend_valid=0, pend_flags=4'b0000. Outputs: status_bits=0, sr_q=0, carry_in=0, flags_pending=0. Reset mid-operation discards any pending update.
- capture = ex_valid & ex_s_bit & ex_cond_met & ~stall & ~flush & ~sr_we.
- Flag computation is combinational from EX inputs. Cin is forwarded C (status_bits[1]).
  - All cmds: N=res[WIDTH-1], Z=(res==0).
  - ADD: {C,res}=a+b. ADC: {C,res}=a+b+Cin. V=(a[msb]==b[msb])&(res[msb]!=a[msb]).
  - SUB/CMP: {C,res}=a+~b+1. SBC: {C,res}=a+~b+Cin. C is NOT-borrow. V=(a[msb]!=b[msb])&(res[msb]!=a[msb]).
  - AND/TST, ORR, EOR, MOV, MVN: res per op; C=ex_shift_carry; V unchanged (forwarded V).
  - Any other cmd: no capture; capture is treated as 0.
- Pipeline, per rising edge:
  - If pend_valid: sr<=pend_flags (commit). Commit occurs even when stall or flush is asserted, because the pending op is older.
  - If capture: pend_flags<=computed, pend_valid<=1. Otherwise pend_valid<=0.
  - Simultaneous commit and capture: the old pend commits to sr while the new value enters pend. No bubble.
- sr_we has top priority: sr<=sr_wdata, pend_valid<=0, and any capture in that cycle is dropped.
- Latency:
  - A computed value is visible on status_bits 1 cycle after capture.
  - It is visible on sr_q 2 cycles after capture, unless overwritten.
- Forwarding: status_bits = pend_valid ? pend_flags : sr; carry_in = status_bits[1].
- Flag computation, commit and forwarding use no extra states and need no stall signal from this block.
- Widths: internal sum is WIDTH+1 bits; no truncation of carry.

Decomposition:
- Shared package (cpu_pkg):
  - alu_cmd constants: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000. CMP shares SUB; TST shares AND.
  - NZCV bit-index constants: N=3, Z=2, C=1, V=0.
- One sub-module, flag_calc: a combinational adder/logic unit plus NZCV generation. The top-level holds the pending/SR registers and the priority logic.

Test Plan:
- Reset: assert rst_n=0 mid-capture -> status_bits=0, sr_q=0, flags_pending=0 immediately (asynchronous).
- ADD, WIDTH=32, a=0x7FFFFFFF, b=1, S=1 -> next cycle status_bits=4'b1001 (N=1, V=1, C=0, Z=0), flags_pending=1; following cycle sr_q=4'b1001.
- SUB a=5, b=5 -> NZCV=0110; then a=3, b=5 -> NZCV=1000. Back-to-back, sr_q follows one cycle behind status_bits.
- Carry chain: ADD a=0xFFFFFFFF, b=1 (C=1, Z=1), then ADC a=0, b=0 in the next cycle -> res=1, forwarded Cin=1, NZCV=0000.
- Suppression:
  - S=1 with ex_cond_met=0, or flush=1, or stall=1 -> no pend update; status_bits unchanged.
  - Logic op AND a=0x80000000, b=0x80000000, shift_carry=1, prior V=1 -> NZCV=1011.
- Direct load: sr_we=1, sr_wdata=4'b0101, same cycle as a valid capture and with a pend already present -> sr_q=0101, flags_pending=0, captured value discarded.
